// File: rtl/ahb_pkg.sv
// Shared AHB encodings and bus dimensions for the 16-master interconnect.
package ahb_pkg;

  localparam int unsigned NUM_MASTERS = 16;
  localparam int unsigned NUM_SLAVES  = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned MST_W       = 4;
  localparam int unsigned SLV_W       = $clog2(NUM_SLAVES);
  localparam int unsigned SEL_W       = $clog2(NUM_SLAVES + 1);
  localparam int unsigned DEFAULT_SLV = NUM_SLAVES;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [2:0] {
    SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
  } hburst_t;

  typedef enum logic [2:0] {
    SIZE_8, SIZE_16, SIZE_32, SIZE_64, SIZE_128, SIZE_256, SIZE_512, SIZE_1024
  } hsize_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  function automatic logic is_active(input htrans_t t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// AHB default slave: answers unmapped NONSEQ/SEQ transfers with a two-cycle
// ERROR response and IDLE/BUSY transfers with a zero-wait OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic    HCLK,
  input  logic    HRESETn,
  input  logic    hready,
  input  logic    unmapped,
  input  htrans_t htrans,
  output logic    hreadyout_c,
  output hresp_t  hresp_c
);

  ds_state_t state;
  ds_state_t state_nxt;
  logic      err_req;

  // A new error sequence starts only when the address phase is accepted
  assign err_req = hready && unmapped && is_active(htrans);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= DS_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    hreadyout_c = 1'b1;
    hresp_c     = OKAY;
    case (state)
      DS_IDLE: begin
        if (err_req) state_nxt = DS_ERR1;
      end
      DS_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = ERROR;
        state_nxt   = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_c   = ERROR;
        state_nxt = err_req ? DS_ERR1 : DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_interconnect.sv
// AHB master/slave multiplexer and address decoder behind the 16-master arbiter;
// owns the data-phase selects, the default slave and the system HREADY.
module ahb_interconnect
  import ahb_pkg::*;
(
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [MST_W-1:0]              HMASTER,
  input  logic                          HMASTLOCK,
  input  logic [NUM_MASTERS*ADDR_W-1:0] M_HADDR,
  input  logic [NUM_MASTERS*2-1:0]      M_HTRANS,
  input  logic [NUM_MASTERS-1:0]        M_HWRITE,
  input  logic [NUM_MASTERS*3-1:0]      M_HSIZE,
  input  logic [NUM_MASTERS*3-1:0]      M_HBURST,
  input  logic [NUM_MASTERS*DATA_W-1:0] M_HWDATA,
  output logic [ADDR_W-1:0]             HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [DATA_W-1:0]             HWDATA,
  output logic                          S_HMASTLOCK,
  output logic [NUM_SLAVES-1:0]         HSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0]  S_HRDATA,
  input  logic [NUM_SLAVES-1:0]         S_HREADYOUT,
  input  logic [NUM_SLAVES*2-1:0]       S_HRESP,
  output logic [DATA_W-1:0]             HRDATA,
  output logic                          HREADY,
  output logic [1:0]                    HRESP,
  output logic [MST_W-1:0]              HMASTER_D
);

  logic [ADDR_W-1:0] m_haddr  [NUM_MASTERS];
  logic [1:0]        m_htrans [NUM_MASTERS];
  logic [2:0]        m_hsize  [NUM_MASTERS];
  logic [2:0]        m_hburst [NUM_MASTERS];
  logic [DATA_W-1:0] m_hwdata [NUM_MASTERS];
  logic [DATA_W-1:0] s_hrdata [NUM_SLAVES];
  logic [1:0]        s_hresp  [NUM_SLAVES];

  logic [3:0]        top_nib;
  logic [SEL_W-1:0]  tgt_sel_c;
  logic [SEL_W-1:0]  dsel;
  logic [MST_W-1:0]  dmaster;
  logic              unmapped;
  logic              ds_ready;
  hresp_t            ds_resp;

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_mst
    assign m_haddr[m]  = M_HADDR[m*ADDR_W +: ADDR_W];
    assign m_htrans[m] = M_HTRANS[m*2 +: 2];
    assign m_hsize[m]  = M_HSIZE[m*3 +: 3];
    assign m_hburst[m] = M_HBURST[m*3 +: 3];
    assign m_hwdata[m] = M_HWDATA[m*DATA_W +: DATA_W];
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slv
    assign s_hrdata[s] = S_HRDATA[s*DATA_W +: DATA_W];
    assign s_hresp[s]  = S_HRESP[s*2 +: 2];
    assign HSEL[s]     = (top_nib == 4'(s));
  end

  // Address phase follows the arbiter's grant with no delay
  assign HADDR       = m_haddr[HMASTER];
  assign HTRANS      = m_htrans[HMASTER];
  assign HWRITE      = M_HWRITE[HMASTER];
  assign HSIZE       = m_hsize[HMASTER];
  assign HBURST      = m_hburst[HMASTER];
  assign S_HMASTLOCK = HMASTLOCK;

  assign top_nib = HADDR[ADDR_W-1 -: 4];

  always_comb begin
    tgt_sel_c = SEL_W'(DEFAULT_SLV);
    if (32'(top_nib) < NUM_SLAVES) tgt_sel_c = SEL_W'(top_nib);
  end

  assign unmapped = (tgt_sel_c == SEL_W'(DEFAULT_SLV));

  // Data-phase owner and target advance only when the bus accepts the address
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dmaster <= '0;
      dsel    <= SEL_W'(DEFAULT_SLV);
    end else if (HREADY) begin
      dmaster <= HMASTER;
      dsel    <= tgt_sel_c;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .hready      (HREADY),
    .unmapped    (unmapped),
    .htrans      (htrans_t'(HTRANS)),
    .hreadyout_c (ds_ready),
    .hresp_c     (ds_resp)
  );

  assign HWDATA    = m_hwdata[dmaster];
  assign HMASTER_D = dmaster;

  // Read/response return path; the default slave never drives read data
  always_comb begin
    HRDATA = '0;
    HREADY = ds_ready;
    HRESP  = ds_resp;
    if (32'(dsel) < NUM_SLAVES) begin
      HRDATA = s_hrdata[dsel[SLV_W-1:0]];
      HREADY = S_HREADYOUT[dsel[SLV_W-1:0]];
      HRESP  = s_hresp[dsel[SLV_W-1:0]];
    end
  end

endmodule

// File: tb/tb_ahb_interconnect.sv
// Self-checking bench for ahb_interconnect: directed scenarios with a per-cycle
// expectation queue for the data-phase return path, then a randomised grant run.
module tb_ahb_interconnect;
  import ahb_pkg::*;

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  md;
  } exp_t;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [3:0]   HMASTER;
  logic         HMASTLOCK;
  logic [511:0] M_HADDR;
  logic [31:0]  M_HTRANS;
  logic [15:0]  M_HWRITE;
  logic [47:0]  M_HSIZE;
  logic [47:0]  M_HBURST;
  logic [511:0] M_HWDATA;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [2:0]   HBURST;
  logic [31:0]  HWDATA;
  logic         S_HMASTLOCK;
  logic [3:0]   HSEL;
  logic [127:0] S_HRDATA;
  logic [3:0]   S_HREADYOUT;
  logic [7:0]   S_HRESP;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [3:0]   HMASTER_D;

  logic [31:0] m_addr  [16];
  logic [1:0]  m_trans [16];
  logic        m_write [16];
  logic [2:0]  m_size  [16];
  logic [2:0]  m_burst [16];
  logic [31:0] m_wdata [16];
  logic [31:0] s_rdata [4];
  logic        s_rdy   [4];
  logic [1:0]  s_resp  [4];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < 16; g++) begin : g_m
    assign M_HADDR[g*32 +: 32] = m_addr[g];
    assign M_HTRANS[g*2 +: 2]  = m_trans[g];
    assign M_HWRITE[g]         = m_write[g];
    assign M_HSIZE[g*3 +: 3]   = m_size[g];
    assign M_HBURST[g*3 +: 3]  = m_burst[g];
    assign M_HWDATA[g*32 +: 32] = m_wdata[g];
  end

  for (genvar g = 0; g < 4; g++) begin : g_s
    assign S_HRDATA[g*32 +: 32] = s_rdata[g];
    assign S_HREADYOUT[g]       = s_rdy[g];
    assign S_HRESP[g*2 +: 2]    = s_resp[g];
  end

  ahb_interconnect dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HBURST(M_HBURST), .M_HWDATA(M_HWDATA), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .S_HMASTLOCK(S_HMASTLOCK), .HSEL(HSEL), .S_HRDATA(S_HRDATA),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .HMASTER_D(HMASTER_D)
  );

  function automatic logic [31:0] wd(input int m);
    return 32'hD0D0_0000 | 32'(m);
  endfunction

  function automatic logic [31:0] rd(input int s);
    return 32'h5EED_0000 | 32'(s);
  endfunction

  function automatic exp_t mk(input logic r, input logic [1:0] p, input logic [31:0] d, input int m);
    return '{rdy: r, resp: p, rdata: d, wdata: wd(m), md: 4'(m)};
  endfunction

  task automatic drv(input int m, input logic [31:0] a, input logic [1:0] t, input logic w);
    HMASTER         = 4'(m);
    m_addr[4'(m)]   = a;
    m_trans[4'(m)]  = t;
    m_write[4'(m)]  = w;
  endtask

  task automatic slv(input int s, input logic r, input logic [1:0] p);
    s_rdy[2'(s)]  = r;
    s_resp[2'(s)] = p;
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle;
    HMASTLOCK = 1'b0;
    drv(0, 32'h0, IDLE, 1'b0);
    for (int s = 0; s < 4; s++) slv(s, 1'b1, OKAY);
    tick;
    tick;
  endtask

  task automatic init_inputs;
    HMASTER   = '0;
    HMASTLOCK = 1'b0;
    for (int m = 0; m < 16; m++) begin
      m_addr[m]  = '0;
      m_trans[m] = IDLE;
      m_write[m] = 1'b0;
      m_size[m]  = SIZE_32;
      m_burst[m] = SINGLE;
      m_wdata[m] = wd(m);
    end
    for (int s = 0; s < 4; s++) begin
      s_rdata[s] = rd(s);
      s_rdy[s]   = 1'b1;
      s_resp[s]  = OKAY;
    end
  endtask

  // Asynchronous reset while a slave is stalling and while the default slave is in ERR1
  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      settle;
      if (k == 0) begin
        drv(5, 32'h2000_0010, NONSEQ, 1'b1);
        slv(2, 1'b0, OKAY);
      end else begin
        drv(5, 32'hF000_0000, NONSEQ, 1'b0);
      end
      tick;
      #2;
      drv(0, 32'hF000_0000, IDLE, 1'b0);
      HRESETn = 1'b0;
      #1;
      n_cmp++; if (HREADY !== 1'b1) begin n_bad++; $display("FAIL reset%0d_hready: got %b want 1", k, HREADY); end
      n_cmp++; if (HRESP !== 2'b00) begin n_bad++; $display("FAIL reset%0d_hresp: got %b want 00", k, HRESP); end
      n_cmp++; if (HMASTER_D !== 4'd0) begin n_bad++; $display("FAIL reset%0d_hmaster_d: got %0d want 0", k, HMASTER_D); end
      n_cmp++; if (HSEL !== 4'b0000) begin n_bad++; $display("FAIL reset%0d_hsel: got %b want 0000", k, HSEL); end
      n_cmp++; if (HRDATA !== 32'h0) begin n_bad++; $display("FAIL reset%0d_hrdata: got %h want 0", k, HRDATA); end
      n_cmp++;
      if ($isunknown({HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, S_HMASTLOCK, HSEL, HRDATA, HREADY, HRESP, HMASTER_D})) begin
        n_bad++; $display("FAIL reset%0d_xfree: outputs contain X/Z, want all known", k);
      end
      @(negedge HCLK);
      HRESETn = 1'b1;
      slv(2, 1'b1, OKAY);
    end
    settle;
  endtask

  // Master 5 write to slave 2: address routing then write data one cycle later
  task automatic test_routing;
    exp_t e;
    settle;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          drv(5, 32'h2000_0010, NONSEQ, 1'b1);
          m_size[5]  = SIZE_32;
          m_burst[5] = INCR4;
          HMASTLOCK  = 1'b1;
          exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
        end
        1: begin
          drv(0, 32'h0, IDLE, 1'b0);
          HMASTLOCK = 1'b0;
          exp_q.push_back(mk(1'b1, OKAY, rd(2), 5));
        end
        default: exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
      endcase
      @(negedge HCLK);
      if (i == 0) begin
        n_cmp++;
        if ({HADDR, HSEL, HTRANS, HWRITE, HSIZE, HBURST, S_HMASTLOCK} !==
            {32'h2000_0010, 4'b0100, 2'b10, 1'b1, 3'b010, 3'b011, 1'b1}) begin
          n_bad++;
          $display("FAIL routing_addr: got haddr=%h hsel=%b trans=%b wr=%b size=%b burst=%b lock=%b want 20000010 0100 10 1 010 011 1",
                   HADDR, HSEL, HTRANS, HWRITE, HSIZE, HBURST, S_HMASTLOCK);
        end
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({HREADY, HRESP, HRDATA, HWDATA, HMASTER_D} !== e) begin
        n_bad++;
        $display("FAIL routing_c%0d: got rdy=%b resp=%b rdata=%h wdata=%h md=%0d want rdy=%b resp=%b rdata=%h wdata=%h md=%0d",
                 i, HREADY, HRESP, HRDATA, HWDATA, HMASTER_D, e.rdy, e.resp, e.rdata, e.wdata, e.md);
      end
      tick;
    end
  endtask

  // Slave 1 stalls a read for three cycles while the grant moves to master 7
  task automatic test_wait_states;
    exp_t e;
    settle;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin
          drv(3, 32'h1000_0040, NONSEQ, 1'b0);
          exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
        end
        1, 2, 3: begin
          drv(7, 32'h3000_0000, NONSEQ, 1'b0);
          slv(1, 1'b0, OKAY);
          exp_q.push_back(mk(1'b0, OKAY, rd(1), 3));
        end
        4: begin
          slv(1, 1'b1, OKAY);
          exp_q.push_back(mk(1'b1, OKAY, rd(1), 3));
        end
        5: begin
          drv(0, 32'h0, IDLE, 1'b0);
          exp_q.push_back(mk(1'b1, OKAY, rd(3), 7));
        end
        default: exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
      endcase
      @(negedge HCLK);
      if (i == 1) begin
        n_cmp++;
        if ({HADDR, HSEL} !== {32'h3000_0000, 4'b1000}) begin
          n_bad++;
          $display("FAIL wait_addr_follow: got haddr=%h hsel=%b want 30000000 1000", HADDR, HSEL);
        end
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({HREADY, HRESP, HRDATA, HWDATA, HMASTER_D} !== e) begin
        n_bad++;
        $display("FAIL wait_c%0d: got rdy=%b resp=%b rdata=%h wdata=%h md=%0d want rdy=%b resp=%b rdata=%h wdata=%h md=%0d",
                 i, HREADY, HRESP, HRDATA, HWDATA, HMASTER_D, e.rdy, e.resp, e.rdata, e.wdata, e.md);
      end
      tick;
    end
  endtask

  // RETRY and SPLIT from slaves pass through and leave the default slave idle
  task automatic test_passthrough;
    exp_t e;
    settle;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin
          drv(2, 32'h0000_0100, NONSEQ, 1'b1);
          exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
        end
        1: begin
          drv(0, 32'h0, IDLE, 1'b0);
          slv(0, 1'b0, RETRY);
          exp_q.push_back(mk(1'b0, RETRY, rd(0), 2));
        end
        2: begin
          slv(0, 1'b1, RETRY);
          exp_q.push_back(mk(1'b1, RETRY, rd(0), 2));
        end
        3: begin
          slv(0, 1'b1, OKAY);
          drv(9, 32'h3000_0000, NONSEQ, 1'b0);
          exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
        end
        4: begin
          drv(0, 32'h0, IDLE, 1'b0);
          slv(3, 1'b1, SPLIT);
          exp_q.push_back(mk(1'b1, SPLIT, rd(3), 9));
        end
        default: begin
          slv(3, 1'b1, OKAY);
          exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
        end
      endcase
      @(negedge HCLK);
      e = exp_q.pop_front();
      n_cmp++;
      if ({HREADY, HRESP, HRDATA, HWDATA, HMASTER_D} !== e) begin
        n_bad++;
        $display("FAIL passthru_c%0d: got rdy=%b resp=%b rdata=%h wdata=%h md=%0d want rdy=%b resp=%b rdata=%h wdata=%h md=%0d",
                 i, HREADY, HRESP, HRDATA, HWDATA, HMASTER_D, e.rdy, e.resp, e.rdata, e.wdata, e.md);
      end
      tick;
    end
  endtask

  // Unmapped NONSEQ gets ERR1/ERR2; unmapped IDLE gets a zero-wait OKAY
  task automatic test_default_slave;
    exp_t e;
    settle;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin
          drv(0, 32'hF000_0000, NONSEQ, 1'b0);
          exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
        end
        1: begin
          drv(0, 32'h0, IDLE, 1'b0);
          exp_q.push_back(mk(1'b0, ERROR, 32'h0, 0));
        end
        2: exp_q.push_back(mk(1'b1, ERROR, 32'h0, 0));
        3: begin
          drv(0, 32'hF000_0000, IDLE, 1'b0);
          exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
        end
        4: begin
          drv(0, 32'h0, IDLE, 1'b0);
          exp_q.push_back(mk(1'b1, OKAY, 32'h0, 0));
        end
        default: exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
      endcase
      @(negedge HCLK);
      if (i == 0) begin
        n_cmp++;
        if (HSEL !== 4'b0000) begin n_bad++; $display("FAIL default_hsel: got %b want 0000", HSEL); end
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({HREADY, HRESP, HRDATA, HWDATA, HMASTER_D} !== e) begin
        n_bad++;
        $display("FAIL default_c%0d: got rdy=%b resp=%b rdata=%h wdata=%h md=%0d want rdy=%b resp=%b rdata=%h wdata=%h md=%0d",
                 i, HREADY, HRESP, HRDATA, HWDATA, HMASTER_D, e.rdy, e.resp, e.rdata, e.wdata, e.md);
      end
      tick;
    end
  endtask

  // Two unmapped NONSEQs then a slave 0 read; slave 0 shows junk response while unselected
  task automatic test_back_to_back;
    exp_t e;
    settle;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin
          drv(4, 32'hF000_0000, NONSEQ, 1'b0);
          exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
        end
        1: begin
          drv(4, 32'hE000_0004, NONSEQ, 1'b0);
          slv(0, 1'b0, RETRY);
          exp_q.push_back(mk(1'b0, ERROR, 32'h0, 4));
        end
        2: exp_q.push_back(mk(1'b1, ERROR, 32'h0, 4));
        3: begin
          drv(4, 32'h0000_0008, NONSEQ, 1'b0);
          exp_q.push_back(mk(1'b0, ERROR, 32'h0, 4));
        end
        4: exp_q.push_back(mk(1'b1, ERROR, 32'h0, 4));
        5: begin
          drv(0, 32'h0, IDLE, 1'b0);
          slv(0, 1'b1, OKAY);
          exp_q.push_back(mk(1'b1, OKAY, rd(0), 4));
        end
        default: exp_q.push_back(mk(1'b1, OKAY, rd(0), 0));
      endcase
      @(negedge HCLK);
      e = exp_q.pop_front();
      n_cmp++;
      if ({HREADY, HRESP, HRDATA, HWDATA, HMASTER_D} !== e) begin
        n_bad++;
        $display("FAIL b2b_c%0d: got rdy=%b resp=%b rdata=%h wdata=%h md=%0d want rdy=%b resp=%b rdata=%h wdata=%h md=%0d",
                 i, HREADY, HRESP, HRDATA, HWDATA, HMASTER_D, e.rdy, e.resp, e.rdata, e.wdata, e.md);
      end
      tick;
    end
  endtask

  // Grant moves randomly on accepted cycles; check decode and delayed write-data routing
  task automatic test_arbiter;
    int          d_m;
    logic        rdy;
    logic [3:0]  want_hsel;
    logic [31:0] a;
    settle;
    d_m = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge HCLK);
      a = m_addr[HMASTER];
      want_hsel = 4'b0000;
      if (a[31:28] < 4'd4) want_hsel[a[29:28]] = 1'b1;
      n_cmp++;
      if (($countones(HSEL) > 1) || (HSEL !== want_hsel)) begin
        n_bad++; $display("FAIL arb_hsel_c%0d: got %b want %b", i, HSEL, want_hsel);
      end
      n_cmp++;
      if ({HWDATA, HMASTER_D} !== {m_wdata[4'(d_m)], 4'(d_m)}) begin
        n_bad++;
        $display("FAIL arb_hwdata_c%0d: got wdata=%h md=%0d want wdata=%h md=%0d", i, HWDATA, HMASTER_D, m_wdata[4'(d_m)], d_m);
      end
      rdy = HREADY;
      tick;
      if (rdy) begin
        d_m     = int'(HMASTER);
        HMASTER = 4'($urandom_range(15));
      end
      for (int m = 0; m < 16; m++) begin
        m_addr[m]  = {4'($urandom_range(15)), 28'($urandom())};
        m_trans[m] = 2'($urandom_range(3));
        m_write[m] = 1'($urandom_range(1));
        m_wdata[m] = $urandom();
      end
      for (int s = 0; s < 4; s++) slv(s, ($urandom_range(3) != 0), OKAY);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0;
    init_inputs;
    tick;
    tick;
    @(negedge HCLK);
    HRESETn = 1'b1;
    test_reset;
    test_routing;
    test_wait_states;
    test_passthrough;
    test_default_slave;
    test_back_to_back;
    test_arbiter;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
